// File: rtl/huff_pkg.sv
// huff_pkg: shared constants, FSM states and table entry layout for the Huffman decoder
package huff_pkg;
    localparam int MAX_LEN_DEF = 24;
    localparam int SYM_N       = 256;
    localparam int LEN_HI      = 63;
    localparam int LEN_LO      = 56;
    localparam int CODE_HI     = 31;
    localparam int CODE_LO     = 0;

    typedef enum logic [2:0] {LOAD, IDLE, FETCH, SHIFT, EMIT, DONE, ERR} state_t;

    typedef struct packed {
        logic [7:0]  len;
        logic [31:0] code;
    } entry_t;
endpackage

// File: rtl/huff_decode_core_if.sv
// huff_decode_core_if: table, bitstream and symbol AXI4-Stream channels of the decoder
interface huff_decode_core_if;
    logic [63:0]  s_axis_tdata_1;
    logic         s_axis_tvalid_1;
    logic         s_axis_tready_1;
    logic [127:0] s_axis_tdata_0;
    logic         s_axis_tvalid_0;
    logic         s_axis_tready_0;
    logic         s_axis_tlast_0;
    logic [7:0]   s_axis_tuser_0;
    logic [7:0]   m_axis_tdata_0;
    logic         m_axis_tvalid_0;
    logic         m_axis_tready_0;
    logic         m_axis_tlast_0;

    modport slave (
        input  s_axis_tdata_1, s_axis_tvalid_1,
        output s_axis_tready_1,
        input  s_axis_tdata_0, s_axis_tvalid_0, s_axis_tlast_0, s_axis_tuser_0,
        output s_axis_tready_0,
        output m_axis_tdata_0, m_axis_tvalid_0, m_axis_tlast_0,
        input  m_axis_tready_0
    );

    modport master (
        output s_axis_tdata_1, s_axis_tvalid_1,
        input  s_axis_tready_1,
        output s_axis_tdata_0, s_axis_tvalid_0, s_axis_tlast_0, s_axis_tuser_0,
        input  s_axis_tready_0,
        input  m_axis_tdata_0, m_axis_tvalid_0, m_axis_tlast_0,
        output m_axis_tready_0
    );
endinterface

// File: rtl/huff_match.sv
// huff_match: parallel compare of the accumulated bits against every table entry, lowest index wins
module huff_match
    import huff_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LW      = $clog2(MAX_LEN) + 1
) (
    input  entry_t             i_tab [SYM_N],
    input  logic [MAX_LEN-1:0] i_acc,
    input  logic [LW-1:0]      i_acc_len,
    output logic               o_hit,
    output logic [7:0]         o_sym
);
    logic [31:0] w_mask;
    logic [31:0] w_acc;

    assign w_mask = ~(32'hFFFF_FFFF << i_acc_len);
    assign w_acc  = 32'(i_acc);

    // Scan from the top so the lowest matching symbol index is the one left standing
    always_comb begin
        o_hit = 1'b0;
        o_sym = '0;
        for (int i = SYM_N - 1; i >= 0; i--)
            if (i_tab[i].len != 8'd0 && i_tab[i].len == 8'(i_acc_len) && (i_tab[i].code & w_mask) == w_acc) begin
                o_hit = 1'b1;
                o_sym = 8'(i);
            end
    end
endmodule

// File: rtl/huff_decode_core.sv
// huff_decode_core: bit-serial Huffman decoder; loads a 256-entry code table, then decodes packed 128-bit beats
module huff_decode_core
    import huff_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    output logic               done,
    output logic               err,
    huff_decode_core_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    state_t             r_state;
    logic [7:0]         r_idx;
    logic [7:0]         r_len  [SYM_N];
    logic [31:0]        r_code [SYM_N];
    logic [127:0]       r_sh;
    logic [7:0]         r_bits;
    logic               r_last;
    logic [MAX_LEN-1:0] r_acc;
    logic [LW-1:0]      r_acc_len;
    logic               r_tvalid;
    logic [7:0]         r_tdata;
    logic               r_tlast;
    logic               r_done;
    logic               r_err;

    entry_t             w_tab [SYM_N];
    logic [7:0]         w_len_in;
    logic [MAX_LEN-1:0] w_acc_nx;
    logic [LW-1:0]      w_len_nx;
    logic               w_hit;
    logic [7:0]         w_sym;
    logic               w_unused;

    assign w_len_in = bus.s_axis_tdata_1[LEN_HI:LEN_LO];
    assign w_acc_nx = MAX_LEN'({r_acc, r_sh[127]});
    assign w_len_nx = r_acc_len + 1'b1;
    assign w_unused = ^bus.s_axis_tdata_1[55:32];

    assign bus.s_axis_tready_1 = (r_state == LOAD);
    assign bus.s_axis_tready_0 = (r_state == FETCH) || (r_state == ERR && !r_last);
    assign bus.m_axis_tvalid_0 = r_tvalid;
    assign bus.m_axis_tdata_0  = r_tdata;
    assign bus.m_axis_tlast_0  = r_tlast;
    assign done                = r_done;
    assign err                 = r_err;

    // Present the table as entries to the match unit
    always_comb
        for (int i = 0; i < SYM_N; i++)
            w_tab[i] = {r_len[i], r_code[i]};

    huff_match #(.MAX_LEN(MAX_LEN), .LW(LW)) u_match (
        .i_tab     (w_tab),
        .i_acc     (w_acc_nx),
        .i_acc_len (w_len_nx),
        .o_hit     (w_hit),
        .o_sym     (w_sym)
    );

    // Code bits need no reset: an entry only matches once its length has been loaded
    always_ff @(posedge aclk)
        if (r_state == LOAD && bus.s_axis_tvalid_1)
            r_code[r_idx] <= bus.s_axis_tdata_1[CODE_HI:CODE_LO];

    // Decoder FSM: table load, beat fetch, per-bit shift/match, symbol emit and error drain
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= LOAD;
            r_idx     <= '0;
            r_sh      <= '0;
            r_bits    <= '0;
            r_last    <= 1'b0;
            r_acc     <= '0;
            r_acc_len <= '0;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_tlast   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            for (int i = 0; i < SYM_N; i++)
                r_len[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD: if (bus.s_axis_tvalid_1) begin
                    r_len[r_idx] <= (int'(w_len_in) > MAX_LEN) ? 8'd0 : w_len_in;
                    r_idx        <= r_idx + 8'd1;
                    if (r_idx == 8'hFF)
                        r_state <= IDLE;
                end
                IDLE: if (start) begin
                    r_acc     <= '0;
                    r_acc_len <= '0;
                    r_err     <= 1'b0;
                    r_state   <= FETCH;
                end
                FETCH: if (bus.s_axis_tvalid_0) begin
                    r_sh    <= bus.s_axis_tdata_0;
                    r_last  <= bus.s_axis_tlast_0;
                    r_bits  <= (bus.s_axis_tlast_0 && bus.s_axis_tuser_0 != 8'd0) ? bus.s_axis_tuser_0 : 8'd128;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_sh   <= r_sh << 1;
                    r_bits <= r_bits - 8'd1;
                    if (w_hit) begin
                        r_acc     <= '0;
                        r_acc_len <= '0;
                        r_tvalid  <= 1'b1;
                        r_tdata   <= w_sym;
                        r_tlast   <= r_last && r_bits == 8'd1;
                        r_state   <= EMIT;
                    end else begin
                        r_acc     <= w_acc_nx;
                        r_acc_len <= w_len_nx;
                        if (w_len_nx == LW'(MAX_LEN) || (r_bits == 8'd1 && r_last)) begin
                            r_err   <= 1'b1;
                            r_state <= ERR;
                        end else if (r_bits == 8'd1)
                            r_state <= FETCH;
                    end
                end
                EMIT: if (bus.m_axis_tready_0) begin
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_done   <= r_bits == 8'd0 && r_last;
                    r_state  <= r_bits != 8'd0 ? SHIFT : r_last ? DONE : FETCH;
                end
                DONE: r_state <= IDLE;
                ERR: if (r_last || (bus.s_axis_tvalid_0 && bus.s_axis_tlast_0))
                    r_state <= IDLE;
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_huff_decode_core.sv
// tb_huff_decode_core: scoreboard bench for the Huffman decoder
module tb_huff_decode_core;
    import huff_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    typedef struct {
        logic [127:0] d;
        logic         l;
        logic [7:0]   u;
    } beat_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic start = 1'b0;
    logic done;
    logic err;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int stall_left = 0;
    bit rand_ready = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0] hold_d;
    logic mon_ready;
    exp_t mon_e;

    exp_t sb[$];
    beat_t bq[$];
    logic [7:0]  t_len  [256];
    logic [31:0] t_code [256];

    huff_decode_core_if bus();

    huff_decode_core dut (
        .aclk    (clk),
        .aresetn (aresetn),
        .start   (start),
        .done    (done),
        .err     (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic expect_sym(input logic [7:0] d, input logic l);
        sb.push_back('{d: d, l: l});
    endtask

    task automatic push_beat(input logic [127:0] d, input logic l, input logic [7:0] u);
        bq.push_back('{d: d, l: l, u: u});
    endtask

    // Output side: handshake, stall stability and scoreboard compare, all on the falling edge
    always @(negedge clk) begin
        if (done)
            done_cnt++;
        if (stall_prev) begin
            check("hold_valid", 32'(bus.m_axis_tvalid_0), 32'd1);
            check("hold_data", 32'(bus.m_axis_tdata_0), 32'(hold_d));
        end
        mon_ready = (stall_left > 0) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        if (bus.m_axis_tvalid_0 && stall_left > 0)
            stall_left--;
        bus.m_axis_tready_0 = mon_ready;
        stall_prev = bus.m_axis_tvalid_0 && !mon_ready;
        hold_d = bus.m_axis_tdata_0;
        if (bus.m_axis_tvalid_0 && mon_ready) begin
            check("sb_has", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sym_data", 32'(bus.m_axis_tdata_0), 32'(mon_e.d));
                check("sym_last", 32'(bus.m_axis_tlast_0), 32'(mon_e.l));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk) aresetn = 1'b0;
        #1;
        check("rst_tready_1", 32'(bus.s_axis_tready_1), 32'd1);
        check("rst_tready_0", 32'(bus.s_axis_tready_0), 32'd0);
        check("rst_tvalid", 32'(bus.m_axis_tvalid_0), 32'd0);
        check("rst_tdata", 32'(bus.m_axis_tdata_0), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk) aresetn = 1'b1;
    endtask

    task automatic load_table();
        int g;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bus.s_axis_tvalid_1 = 1'b1;
            bus.s_axis_tdata_1 = {t_len[i], 24'h0, t_code[i]};
            g = 0;
            while (!bus.s_axis_tready_1 && g < 50) begin
                @(negedge clk);
                g++;
            end
        end
        @(negedge clk) bus.s_axis_tvalid_1 = 1'b0;
        check("load_done", 32'(bus.s_axis_tready_1), 32'd0);
    endtask

    task automatic send_frame();
        beat_t b;
        int g;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("err_clr", 32'(err), 32'd0);
        while (bq.size() != 0) begin
            b = bq.pop_front();
            bus.s_axis_tvalid_0 = 1'b1;
            bus.s_axis_tdata_0 = b.d;
            bus.s_axis_tlast_0 = b.l;
            bus.s_axis_tuser_0 = b.u;
            g = 0;
            while (!bus.s_axis_tready_0 && g < 2000) begin
                @(negedge clk);
                g++;
            end
            check("beat_take", 32'(bus.s_axis_tready_0), 32'd1);
            @(negedge clk) bus.s_axis_tvalid_0 = 1'b0;
        end
    endtask

    task automatic finish_frame(input int d0, input int exp_done, input logic exp_err);
        int g = 0;
        while (done_cnt == d0 && !err && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("frame_end", 32'(g < 3000), 32'd1);
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("done_cnt", 32'(done_cnt - d0), 32'(exp_done));
        check("frame_err", 32'(err), 32'(exp_err));
    endtask

    task automatic frame_a();
        int d0 = done_cnt;
        push_beat({6'b010110, 122'b0}, 1'b1, 8'd6);
        expect_sym(8'h41, 1'b0);
        expect_sym(8'h42, 1'b0);
        expect_sym(8'h43, 1'b0);
        expect_sym(8'h41, 1'b1);
        send_frame();
        finish_frame(d0, 1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [127:0] w;
        bus.s_axis_tvalid_1 = 1'b0;
        bus.s_axis_tdata_1 = '0;
        bus.s_axis_tvalid_0 = 1'b0;
        bus.s_axis_tdata_0 = '0;
        bus.s_axis_tlast_0 = 1'b0;
        bus.s_axis_tuser_0 = '0;
        do_reset();

        for (int i = 0; i < 256; i++) begin
            t_len[i] = 8'd0;
            t_code[i] = 32'd0;
        end
        t_len[8'h41] = 8'd1; t_code[8'h41] = 32'b0;
        t_len[8'h42] = 8'd2; t_code[8'h42] = 32'b10;
        t_len[8'h43] = 8'd2; t_code[8'h43] = 32'b11;
        load_table();

        frame_a();

        rand_ready = 1'b1;
        d0 = done_cnt;
        push_beat({2'b10, 125'b0, 1'b1}, 1'b0, 8'd0);
        push_beat(128'b0, 1'b1, 8'd2);
        expect_sym(8'h42, 1'b0);
        for (int i = 0; i < 125; i++)
            expect_sym(8'h41, 1'b0);
        expect_sym(8'h42, 1'b0);
        expect_sym(8'h41, 1'b1);
        send_frame();
        finish_frame(d0, 1, 1'b0);
        rand_ready = 1'b0;

        stall_left = 5;
        frame_a();
        check("stall_used", 32'(stall_left), 32'd0);

        d0 = done_cnt;
        push_beat({1'b1, 127'b0}, 1'b1, 8'd1);
        send_frame();
        finish_frame(d0, 0, 1'b1);

        frame_a();

        do_reset();
        for (int i = 0; i < 256; i++) begin
            t_len[i] = 8'd8;
            t_code[i] = 32'(i);
        end
        load_table();
        d0 = done_cnt;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++)
                w[127 - 8 * i -: 8] = 8'(16 * b + i);
            push_beat(w, b == 1, 8'd0);
        end
        for (int i = 0; i < 32; i++)
            expect_sym(8'(i), i == 31);
        send_frame();
        finish_frame(d0, 1, 1'b0);

        push_beat(128'b0, 1'b0, 8'd0);
        send_frame();
        repeat (3) @(negedge clk);
        do_reset();

        for (int i = 0; i < 256; i++) begin
            t_len[i] = 8'd0;
            t_code[i] = 32'd0;
        end
        t_len[8'h07] = 8'h41; t_code[8'h07] = 32'b0;
        t_len[8'h05] = 8'd3;  t_code[8'h05] = 32'b101;
        t_len[8'h09] = 8'd3;  t_code[8'h09] = 32'b101;
        t_len[8'h0A] = 8'd1;  t_code[8'h0A] = 32'b0;
        load_table();
        d0 = done_cnt;
        push_beat({4'b1010, 124'b0}, 1'b1, 8'd4);
        expect_sym(8'h05, 1'b0);
        expect_sym(8'h0A, 1'b1);
        send_frame();
        finish_frame(d0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
